// File: rtl/dcache_amo_unit_pkg.sv
// Shared definitions for the DCache AMO responder: opcode encodings and FSM states.
package dcache_amo_unit_pkg;

  localparam logic [3:0] AMO_LR   = 4'd0;
  localparam logic [3:0] AMO_SC   = 4'd1;
  localparam logic [3:0] AMO_SWAP = 4'd2;
  localparam logic [3:0] AMO_ADD  = 4'd3;
  localparam logic [3:0] AMO_XOR  = 4'd4;
  localparam logic [3:0] AMO_AND  = 4'd5;
  localparam logic [3:0] AMO_OR   = 4'd6;
  localparam logic [3:0] AMO_MIN  = 4'd7;
  localparam logic [3:0] AMO_MAX  = 4'd8;
  localparam logic [3:0] AMO_MINU = 4'd9;
  localparam logic [3:0] AMO_MAXU = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_R,
    S_MISS,
    S_WAIT_REFILL,
    S_WRITE,
    S_RESP
  } state_t;

endpackage

// File: rtl/dcache_amo_unit_alu.sv
// Combinational AMO arithmetic: computes the value to write back from the old value and rs2.
module amo_alu
  import dcache_amo_unit_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op,
  input  logic            word,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] new_val
);

  logic [31:0]     a32, b32, r32;
  logic [XLEN-1:0] r64;

  always_comb begin
    a32 = old[31:0];
    b32 = operand[31:0];
    r32 = b32;
    r64 = operand;
    // Unknown opcodes and SC fall through to a plain store of rs2.
    case (op)
      AMO_SWAP: begin r32 = b32;       r64 = operand;       end
      AMO_ADD:  begin r32 = a32 + b32; r64 = old + operand; end
      AMO_XOR:  begin r32 = a32 ^ b32; r64 = old ^ operand; end
      AMO_AND:  begin r32 = a32 & b32; r64 = old & operand; end
      AMO_OR:   begin r32 = a32 | b32; r64 = old | operand; end
      AMO_MIN: begin
        r32 = ($signed(a32) < $signed(b32)) ? a32 : b32;
        r64 = ($signed(old) < $signed(operand)) ? old : operand;
      end
      AMO_MAX: begin
        r32 = ($signed(a32) > $signed(b32)) ? a32 : b32;
        r64 = ($signed(old) > $signed(operand)) ? old : operand;
      end
      AMO_MINU: begin
        r32 = (a32 < b32) ? a32 : b32;
        r64 = (old < operand) ? old : operand;
      end
      AMO_MAXU: begin
        r32 = (a32 > b32) ? a32 : b32;
        r64 = (old > operand) ? old : operand;
      end
      default: begin r32 = b32; r64 = operand; end
    endcase
    new_val = word ? {{(XLEN-32){1'b0}}, r32} : r64;
  end

endmodule

// File: rtl/dcache_amo_unit.sv
// DCache-side AMO/LR/SC responder: array lookup, read-modify-write, reservation tracking, miss refill.
// Optional macro AMO_RESV_TIMEOUT_EN bounds reservation lifetime to RESV_TIMEOUT cycles.
module dcache_amo_unit
  import dcache_amo_unit_pkg::*;
#(
  parameter int PADDR_W      = 34,
  parameter int XLEN         = 64,
  parameter int OP_W         = 4,
  parameter int LINE_OFF     = 6,
  parameter int RESV_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               amo_req,
  output logic               amo_ready,
  input  logic [PADDR_W-1:0] amo_paddr,
  input  logic [XLEN-1:0]    amo_data,
  input  logic [OP_W-1:0]    amo_op,
  input  logic               amo_word,
  input  logic [7:0]         amo_mask,
  output logic               amo_success,
  output logic               amo_refill,
  output logic [XLEN-1:0]    amo_rdata,
  output logic               arr_req,
  input  logic               arr_ready,
  output logic               arr_we,
  output logic [PADDR_W-1:0] arr_addr,
  output logic [XLEN-1:0]    arr_wdata,
  output logic [7:0]         arr_wmask,
  input  logic               arr_rvalid,
  input  logic               arr_hit,
  input  logic [XLEN-1:0]    arr_rdata,
  output logic               miss_req,
  output logic [PADDR_W-1:0] miss_addr,
  input  logic               miss_ready,
  input  logic               refill_done,
  input  logic               inv_valid,
  input  logic [PADDR_W-1:0] inv_addr,
  input  logic               st_valid,
  input  logic [PADDR_W-1:0] st_paddr
);

  localparam logic [PADDR_W-1:0] WORD_MASK = {{(PADDR_W-3){1'b1}}, 3'b000};
  localparam logic [PADDR_W-1:0] LINE_MASK = {{(PADDR_W-LINE_OFF){1'b1}}, {LINE_OFF{1'b0}}};

  state_t              state_reg, state_next;
  logic [PADDR_W-1:0]  paddr_reg;
  logic [XLEN-1:0]     data_reg, result_reg, new_reg;
  logic [OP_W-1:0]     op_reg;
  logic                word_reg;
  logic [7:0]          mask_reg;
  logic                resv_valid_reg;
  logic [PADDR_W-1:0]  resv_addr_reg;

  logic [XLEN-1:0]     old_lane, alu_out;
  logic [PADDR_W-1:0]  line_addr;
  logic                lookup_hit, lr_set, sc_chk, sc_ok, ext_clear, wr_clear, timeout_now;

  assign line_addr = paddr_reg & LINE_MASK;
  assign old_lane  = !word_reg ? arr_rdata :
                     {{(XLEN-32){1'b0}}, (paddr_reg[2] ? arr_rdata[63:32] : arr_rdata[31:0])};

  amo_alu #(.XLEN(XLEN), .OP_W(OP_W)) u_alu (
    .op      (op_reg),
    .word    (word_reg),
    .old     (old_lane),
    .operand (data_reg),
    .new_val (alu_out)
  );

  assign lookup_hit = (state_reg == S_WAIT_R) && arr_rvalid && arr_hit;
  assign lr_set     = lookup_hit && (op_reg == AMO_LR);
  assign sc_chk     = lookup_hit && (op_reg == AMO_SC);

  // Clears arriving in the same cycle as the SC check must make the SC fail.
  assign ext_clear = resv_valid_reg &&
                     ((inv_valid && ((inv_addr & LINE_MASK) == resv_addr_reg)) ||
                      (st_valid  && ((st_paddr & LINE_MASK) == resv_addr_reg)) ||
                      timeout_now);
  assign wr_clear  = (state_reg == S_WRITE) && arr_ready && (line_addr == resv_addr_reg);
  assign sc_ok     = resv_valid_reg && (line_addr == resv_addr_reg) && !ext_clear;

`ifdef AMO_RESV_TIMEOUT_EN
  localparam int CNT_W = $clog2(RESV_TIMEOUT + 1);
  logic [CNT_W-1:0] resv_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      resv_cnt_reg <= '0;
    else if (lr_set)
      resv_cnt_reg <= CNT_W'(RESV_TIMEOUT);
    else if (resv_cnt_reg != '0)
      resv_cnt_reg <= resv_cnt_reg - 1'b1;
  end

  assign timeout_now = resv_valid_reg && (resv_cnt_reg == '0);
`else
  assign timeout_now = 1'b0;
`endif

  // LR set has priority over any simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resv_valid_reg <= 1'b0;
      resv_addr_reg  <= '0;
    end else if (lr_set) begin
      resv_valid_reg <= 1'b1;
      resv_addr_reg  <= line_addr;
    end else if (sc_chk || ext_clear || wr_clear) begin
      resv_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      paddr_reg  <= '0;
      data_reg   <= '0;
      op_reg     <= '0;
      word_reg   <= 1'b0;
      mask_reg   <= '0;
      result_reg <= '0;
      new_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && amo_req) begin
        paddr_reg <= amo_paddr;
        data_reg  <= amo_data;
        op_reg    <= amo_op;
        word_reg  <= amo_word;
        mask_reg  <= amo_mask;
      end
      if (lookup_hit) begin
        new_reg <= alu_out;
        if (sc_chk)
          result_reg <= sc_ok ? '0 : {{(XLEN-1){1'b0}}, 1'b1};
        else
          result_reg <= old_lane;
      end
    end
  end

  // Held low while reset is asserted so every output reads zero in reset.
  assign amo_ready = (state_reg == S_IDLE) && rst;

  always_comb begin
    state_next  = state_reg;
    arr_req     = 1'b0;
    arr_we      = 1'b0;
    arr_addr    = '0;
    arr_wdata   = '0;
    arr_wmask   = '0;
    miss_req    = 1'b0;
    miss_addr   = '0;
    amo_success = 1'b0;
    amo_refill  = 1'b0;
    amo_rdata   = '0;
    case (state_reg)
      S_IDLE: if (amo_req) state_next = S_READ;
      S_READ: begin
        arr_req  = 1'b1;
        arr_addr = paddr_reg & WORD_MASK;
        if (arr_ready) state_next = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (arr_rvalid) begin
          if (!arr_hit)               state_next = S_MISS;
          else if (op_reg == AMO_LR)  state_next = S_RESP;
          else if (op_reg == AMO_SC)  state_next = sc_ok ? S_WRITE : S_RESP;
          else                        state_next = S_WRITE;
        end
      end
      S_MISS: begin
        miss_req  = 1'b1;
        miss_addr = line_addr;
        if (miss_ready) state_next = S_WAIT_REFILL;
      end
      S_WAIT_REFILL: begin
        if (refill_done) begin
          amo_refill = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WRITE: begin
        arr_req   = 1'b1;
        arr_we    = 1'b1;
        arr_addr  = paddr_reg & WORD_MASK;
        arr_wmask = mask_reg;
        arr_wdata = word_reg ? {new_reg[31:0], new_reg[31:0]} : new_reg;
        if (arr_ready) state_next = S_RESP;
      end
      S_RESP: begin
        amo_success = 1'b1;
        amo_rdata   = result_reg;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_amo_unit.sv
// Directed self-checking bench for dcache_amo_unit with small array and miss-handler responders.
module tb_dcache_amo_unit;
  import dcache_amo_unit_pkg::*;

  localparam int RESV_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        amo_req;
  logic        amo_ready;
  logic [33:0] amo_paddr;
  logic [63:0] amo_data;
  logic [3:0]  amo_op;
  logic        amo_word;
  logic [7:0]  amo_mask;
  logic        amo_success, amo_refill;
  logic [63:0] amo_rdata;
  logic        arr_req, arr_ready, arr_we;
  logic [33:0] arr_addr;
  logic [63:0] arr_wdata;
  logic [7:0]  arr_wmask;
  logic        arr_rvalid = 1'b0;
  logic        arr_hit;
  logic [63:0] arr_rdata;
  logic        miss_req, miss_ready;
  logic [33:0] miss_addr;
  logic        refill_done = 1'b0;
  logic        inv_valid, st_valid;
  logic [33:0] inv_addr, st_paddr;

  logic        hit_flag;
  logic [63:0] mem_word;
  logic        wr_en;
  int          wr_cnt = 0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_mask = '0;
  logic [33:0] wr_addr = '0;
  int          miss_hold = 0;
  int          miss_cycles = 0;
  int          refill_delay = 0;
  logic [33:0] miss_addr_seen = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_amo_unit #(.RESV_TIMEOUT(RESV_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .amo_req(amo_req), .amo_ready(amo_ready), .amo_paddr(amo_paddr), .amo_data(amo_data),
    .amo_op(amo_op), .amo_word(amo_word), .amo_mask(amo_mask),
    .amo_success(amo_success), .amo_refill(amo_refill), .amo_rdata(amo_rdata),
    .arr_req(arr_req), .arr_ready(arr_ready), .arr_we(arr_we), .arr_addr(arr_addr),
    .arr_wdata(arr_wdata), .arr_wmask(arr_wmask), .arr_rvalid(arr_rvalid),
    .arr_hit(arr_hit), .arr_rdata(arr_rdata),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .refill_done(refill_done),
    .inv_valid(inv_valid), .inv_addr(inv_addr), .st_valid(st_valid), .st_paddr(st_paddr)
  );

  // Array model: grants reads immediately, writes only when wr_en; lookup answers next cycle.
  assign arr_ready = arr_req && (!arr_we || wr_en);
  assign arr_hit   = hit_flag;
  assign arr_rdata = mem_word;

  always @(posedge clk) begin
    arr_rvalid <= arr_req && arr_ready && !arr_we;
    if (arr_req && arr_ready && arr_we) begin
      wr_cnt  <= wr_cnt + 1;
      wr_data <= arr_wdata;
      wr_mask <= arr_wmask;
      wr_addr <= arr_addr;
    end
  end

  // Miss handler model: stalls 3 cycles before accepting, then refills 2 cycles later.
  assign miss_ready = miss_req && (miss_hold >= 3);

  always @(posedge clk) begin
    refill_done <= 1'b0;
    if (miss_req) begin
      miss_cycles    <= miss_cycles + 1;
      miss_addr_seen <= miss_addr;
    end
    if (miss_req && !miss_ready) miss_hold <= miss_hold + 1;
    if (miss_req && miss_ready) begin
      miss_hold    <= 0;
      refill_delay <= 2;
    end else if (refill_delay > 0) begin
      refill_delay <= refill_delay - 1;
      if (refill_delay == 1) refill_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_amo(input logic [33:0] a, input logic [63:0] d, input logic [3:0] op,
                         input logic w, input logic [7:0] m,
                         output logic succ, output logic refl, output logic [63:0] rd,
                         output int pulses, output logic ready_low);
    int n;
    @(negedge clk);
    amo_req = 1'b1; amo_paddr = a; amo_data = d; amo_op = op; amo_word = w; amo_mask = m;
    n = 0;
    while (!amo_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 amo_req = 1'b0;
    succ = 1'b0; refl = 1'b0; rd = '0; pulses = 0; ready_low = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (amo_ready) ready_low = 1'b0;
      if (amo_success) begin pulses++; succ = 1'b1; rd = amo_rdata; end
      if (amo_refill)  begin pulses++; refl = 1'b1; end
      if (succ || refl) break;
    end
    @(negedge clk);
    if (amo_success || amo_refill) pulses++;
    $display("txn op=%0d addr=%h data=%h word=%0b -> success=%0b refill=%0b rdata=%h pulses=%0d",
             op, a, d, w, succ, refl, rd, pulses);
  endtask

  logic        s, r, rl;
  logic [63:0] rd;
  int          p, w0, m0, n;

  initial begin
    rst = 1'b0; amo_req = 1'b0; amo_paddr = '0; amo_data = '0; amo_op = '0;
    amo_word = 1'b0; amo_mask = '0; inv_valid = 1'b0; inv_addr = '0;
    st_valid = 1'b0; st_paddr = '0; hit_flag = 1'b1; mem_word = '0; wr_en = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_ready",   {63'd0, amo_ready},   64'd0);
    check("reset_arr_req", {63'd0, arr_req},     64'd0);
    check("reset_miss",    {63'd0, miss_req},    64'd0);
    check("reset_success", {63'd0, amo_success}, 64'd0);
    check("reset_rdata",   amo_rdata,            64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {63'd0, amo_ready}, 64'd1);

    // 64-bit ADD hit
    mem_word = 64'h5; w0 = wr_cnt;
    run_amo(34'h1000, 64'h3, AMO_ADD, 1'b0, 8'hFF, s, r, rd, p, rl);
    check("add_success",   {63'd0, s},  64'd1);
    check("add_rdata",     rd,          64'h5);
    check("add_pulses",    64'(p),      64'd1);
    check("add_ready_low", {63'd0, rl}, 64'd1);
    check("add_wr_cnt",    64'(wr_cnt - w0), 64'd1);
    check("add_wdata",     wr_data,     64'h8);
    check("add_wmask",     {56'd0, wr_mask}, 64'hFF);
    check("add_waddr",     {30'd0, wr_addr}, 64'h1000);

    // Word MIN on the upper lane, signed
    mem_word = 64'hFFFFFFFE_12345678;
    run_amo(34'h1004, 64'h1, AMO_MIN, 1'b1, 8'hF0, s, r, rd, p, rl);
    check("wmin_rdata",  rd,      64'h00000000_FFFFFFFE);
    check("wmin_wdata",  wr_data, 64'hFFFFFFFE_FFFFFFFE);
    check("wmin_wmask",  {56'd0, wr_mask}, 64'hF0);
    check("wmin_waddr",  {30'd0, wr_addr}, 64'h1000);

    // Word MAXU on the lower lane
    mem_word = 64'h00000000_80000000;
    run_amo(34'h1100, 64'h7FFFFFFF, AMO_MAXU, 1'b1, 8'h0F, s, r, rd, p, rl);
    check("wmaxu_rdata", rd,      64'h00000000_80000000);
    check("wmaxu_wdata", wr_data, 64'h80000000_80000000);

    // LR then SC succeeds, second SC fails without writing
    mem_word = 64'h1111; w0 = wr_cnt;
    run_amo(34'h2000, 64'h0, AMO_LR, 1'b0, 8'hFF, s, r, rd, p, rl);
    check("lr_rdata",  rd, 64'h1111);
    check("lr_no_wr",  64'(wr_cnt - w0), 64'd0);
    run_amo(34'h2008, 64'hABC, AMO_SC, 1'b0, 8'hFF, s, r, rd, p, rl);
    check("sc1_rdata", rd, 64'd0);
    check("sc1_wr",    64'(wr_cnt - w0), 64'd1);
    check("sc1_wdata", wr_data, 64'hABC);
    run_amo(34'h2008, 64'hDEF, AMO_SC, 1'b0, 8'hFF, s, r, rd, p, rl);
    check("sc2_rdata", rd, 64'd1);
    check("sc2_no_wr", 64'(wr_cnt - w0), 64'd1);

    // Invalidation of the reserved line kills the reservation
    run_amo(34'h3000, 64'h0, AMO_LR, 1'b0, 8'hFF, s, r, rd, p, rl);
    @(negedge clk); inv_valid = 1'b1; inv_addr = 34'h3020;
    @(negedge clk); inv_valid = 1'b0;
    w0 = wr_cnt;
    run_amo(34'h3000, 64'h5, AMO_SC, 1'b0, 8'hFF, s, r, rd, p, rl);
    check("inv_sc_rdata", rd, 64'd1);
    check("inv_sc_no_wr", 64'(wr_cnt - w0), 64'd0);

    // A store to a neighbouring line leaves the reservation intact
    run_amo(34'h4000, 64'h0, AMO_LR, 1'b0, 8'hFF, s, r, rd, p, rl);
    @(negedge clk); st_valid = 1'b1; st_paddr = 34'h4040;
    @(negedge clk); st_valid = 1'b0;
    run_amo(34'h4000, 64'h9, AMO_SC, 1'b0, 8'hFF, s, r, rd, p, rl);
    check("st_other_sc_rdata", rd, 64'd0);

`ifdef AMO_RESV_TIMEOUT_EN
    run_amo(34'h7000, 64'h0, AMO_LR, 1'b0, 8'hFF, s, r, rd, p, rl);
    repeat (RESV_TIMEOUT + 4) @(negedge clk);
    run_amo(34'h7000, 64'h1, AMO_SC, 1'b0, 8'hFF, s, r, rd, p, rl);
    check("timeout_sc_rdata", rd, 64'd1);
`endif

    // Miss: line-aligned fill request held through back-pressure, one refill pulse
    hit_flag = 1'b0; mem_word = 64'h10; m0 = miss_cycles; w0 = wr_cnt;
    run_amo(34'h5010, 64'h1, AMO_ADD, 1'b0, 8'hFF, s, r, rd, p, rl);
    check("miss_refill",  {63'd0, r}, 64'd1);
    check("miss_success", {63'd0, s}, 64'd0);
    check("miss_pulses",  64'(p),     64'd1);
    check("miss_addr",    {30'd0, miss_addr_seen}, 64'h5000);
    check("miss_cycles",  64'(miss_cycles - m0), 64'd4);
    check("miss_no_wr",   64'(wr_cnt - w0), 64'd0);
    hit_flag = 1'b1;
    run_amo(34'h5010, 64'h1, AMO_ADD, 1'b0, 8'hFF, s, r, rd, p, rl);
    check("retry_success", {63'd0, s}, 64'd1);
    check("retry_rdata",   rd,         64'h10);
    check("retry_wdata",   wr_data,    64'h11);

    // Reset while stalled in WRITE aborts the op and drops the reservation
    run_amo(34'h6000, 64'h0, AMO_LR, 1'b0, 8'hFF, s, r, rd, p, rl);
    wr_en = 1'b0; w0 = wr_cnt;
    @(negedge clk);
    amo_req = 1'b1; amo_paddr = 34'h6000; amo_data = 64'h1; amo_op = AMO_ADD;
    amo_word = 1'b0; amo_mask = 8'hFF;
    n = 0;
    while (!(arr_req && arr_we) && n < 20) begin @(negedge clk); n++; end
    check("rst_reached_write", {63'd0, arr_we}, 64'd1);
    amo_req = 1'b0;
    rst = 1'b0; #1;
    check("rst_arr_req",  {63'd0, arr_req},     64'd0);
    check("rst_success",  {63'd0, amo_success}, 64'd0);
    check("rst_refill",   {63'd0, amo_refill},  64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1; wr_en = 1'b1;
    @(negedge clk);
    check("rst_idle_ready", {63'd0, amo_ready}, 64'd1);
    check("rst_no_wr",      64'(wr_cnt - w0),   64'd0);
    w0 = wr_cnt;
    run_amo(34'h6000, 64'h2, AMO_SC, 1'b0, 8'hFF, s, r, rd, p, rl);
    check("rst_sc_rdata", rd, 64'd1);
    check("rst_sc_no_wr", 64'(wr_cnt - w0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_amo_unit.md
Name: dcache_amo_unit

Overview:
- DCache-side responder for the atomic-memory-operation request channel.
- Accepts one AMO/LR/SC request at a time and looks up the line in the DCache arrays.
- On a hit: performs the read-modify-write, tracks the LR/SC reservation, and returns the old value with a one-cycle success pulse.
- On a miss: requests a line fill and pulses refill, so the initiator re-issues the request.

Parameters:
- PADDR_W, 34, physical address width
- XLEN, 64, data width (RV64)
- OP_W, 4, AMO opcode width
- LINE_OFF, 6, log2 of line bytes; reservation granule is one line
- RESV_TIMEOUT, 64, reservation lifetime in cycles (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- amo_req  in  1  request valid, held until ready
- amo_ready  out  1  request accepted this cycle
- amo_paddr  in  PADDR_W  target address
- amo_data  in  XLEN  rs2 operand
- amo_op  in  OP_W  opcode
- amo_word  in  1  32-bit operation
- amo_mask  in  8  byte write mask
- amo_success  out  1  one-cycle completion pulse
- amo_refill  out  1  one-cycle retry pulse after miss fill
- amo_rdata  out  XLEN  result, valid with amo_success
- arr_req  out  1  array access request
- arr_ready  in  1  array grant
- arr_we  out  1  write
- arr_addr  out  PADDR_W  8-byte aligned address
- arr_wdata  out  XLEN  write data
- arr_wmask  out  8  byte mask
- arr_rvalid  in  1  lookup result valid
- arr_hit  in  1  lookup hit
- arr_rdata  in  XLEN  aligned 8-byte word
- miss_req  out  1  fill request
- miss_addr  out  PADDR_W  line address (offset bits zero)
- miss_ready  in  1  fill request accepted
- refill_done  in  1  fill of miss_addr complete
- inv_valid  in  1  snoop/eviction of a line
- inv_addr  in  PADDR_W  invalidated address
- st_valid  in  1  store-buffer write committed to the DCache
- st_paddr  in  PADDR_W  store address

Behaviour:
- Reset: all outputs 0; state IDLE; reservation invalid.
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-low.
- Handshake:
  - amo_ready = (state==IDLE).
  - On amo_req & amo_ready, latch paddr, data, op, word, mask and go to READ.
- States:
  - READ: arr_req=1, arr_we=0, arr_addr=paddr with bits[2:0]=0. On arr_ready go to WAIT_R.
  - WAIT_R: wait for arr_rvalid.
    - Miss: go to MISS.
    - Hit, op=LR: set reservation to paddr[PADDR_W-1:LINE_OFF]; result=old; go to RESP.
    - Hit, op=SC, reservation valid and line match: result=0, go to WRITE.
    - Hit, op=SC, otherwise: result=1, go to RESP.
    - SC always clears the reservation.
    - Hit, other ops: new=f(old, data), result=old, go to WRITE.
  - MISS: miss_req=1 until miss_ready, then go to WAIT_REFILL.
  - WAIT_REFILL: on refill_done, amo_refill=1 for one cycle, go to IDLE. The initiator re-raises amo_req.
  - WRITE: arr_req=1, arr_we=1, arr_wmask=latched mask, arr_wdata=new replicated into both halves when word=1. On arr_ready go to RESP.
  - RESP: amo_success=1 and amo_rdata=result for one cycle, then go to IDLE.
- Word lane selection: word=1 selects arr_rdata[63:32] if paddr[2], else [31:0]. The ALU runs in 32 bits. amo_rdata holds the 32-bit lane zero-extended; the initiator sign-extends.
- ALU ops: SWAP, ADD (wraps), XOR, AND, OR, MIN/MAX (signed at operand width), MINU/MAXU.
- Reservation clears when any of these occurs with a matching line:
  - inv_valid with a line match;
  - st_valid with a line match;
  - a completed AMO write to the same line.
- Simultaneous events:
  - A clear on the same cycle as the SC check makes the SC fail.
  - LR set and a clear on the same cycle: the set wins.
- A new LR overwrites the existing reservation.
- A miss never modifies the reservation.
- Reset mid-operation aborts the operation: no write and no pulse.

Optional Feature:
- Macro: AMO_RESV_TIMEOUT_EN.
- Defined: a counter loads RESV_TIMEOUT on LR set and decrements each cycle. The reservation clears when the counter reaches 0, bounding LR/SC livelock.
- Undefined: no counter; the reservation persists until one of the clear events.

Decomposition:
- Shared package holds:
  - AMO opcode constants: LR=0, SC=1, SWAP=2, ADD=3, XOR=4, AND=5, OR=6, MIN=7, MAX=8, MINU=9, MAXU=10;
  - the state enum.
- One sub-module, amo_alu: combinational op/word/operand in, new value out.

Test Plan:
- Hit ADD: word=0, old=0x5, data=0x3 -> write 0x8, amo_rdata=0x5, one success pulse, amo_ready low throughout.
- Word MIN: paddr[2]=1, old hi=0xFFFFFFFE, data=0x1 -> write lane 0xFFFFFFFE unchanged, mask 0xF0, rdata=0x00000000FFFFFFFE.
- LR then SC to the same line -> SC writes, rdata=0. A second SC -> rdata=1 and no arr write.
- LR, then inv_valid on the same line, then SC -> rdata=1. With AMO_RESV_TIMEOUT_EN, LR followed by an idle RESV_TIMEOUT cycles then SC -> rdata=1.
- Miss -> miss_req with line-aligned addr, hold through miss_ready=0 for 3 cycles, refill_done -> single amo_refill pulse. Re-request then hits and succeeds.
- Assert rst during WRITE -> arr_req, amo_success and amo_refill are 0; state IDLE; reservation invalid.
